ahb_decoder_mux: RTL
====================

// Module: ahb_decoder_mux
// PURPOSE
//  AHB-Lite address decoder + slave-to-master response multiplexer; sits between the master and all slaves.
//  Decodes HADDR into one-hot HSEL for NUM_SLAVES mapped slaves plus the default slave (unmapped space).
//  Registers the address-phase selection into the data phase and muxes the chosen slave's HRDATA, HREADYOUT and HRESP back to the master.
// PARAMETERS
//  NUM_SLAVES  4  mapped slaves, 1..8
//  BASE_ADDRS  {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}  flat 32*NUM_SLAVES; slave i at [32*i+:32]
//  ADDR_MASKS  {4{32'hF000_0000}}  flat 32*NUM_SLAVES; slave i matches when (HADDR & MASK_i)==BASE_i
//  WD_LIMIT    16  watchdog wait-state limit, 1..2^WD_WIDTH-1 (DECODER_WATCHDOG_EN only)
//  WD_WIDTH    5   watchdog counter width
// PORTS
//  HMASTCLOCK   in   1             bus clock; all state on rising edge
//  reset        in   1             synchronous, active-high
//  HADDR        in   32            master address-phase address
//  HTRANS       in   2             master transfer type; HTRANS[1]=1 is NONSEQ/SEQ
//  HSEL_S       out  NUM_SLAVES    one-hot select, mapped slaves
//  HSEL_DEF     out  1             default slave select
//  HRDATA_S     in   32*NUM_SLAVES slave read data, flat
//  HREADYOUT_S  in   NUM_SLAVES    slave ready
//  HRESP_S      in   NUM_SLAVES    slave response (1=ERROR)
//  HRDATA_DEF   in   32            default slave read data
//  HREADYOUT_DEF in  1             default slave ready
//  HRESP_DEF    in   1             default slave response
//  HRDATA       out  32            to master
//  HREADY       out  1             to master and fed back to all slaves' HREADY
//  HRESP        out  1             to master
// BEHAVIOUR
//  - Decode, combinational: lowest index i with (HADDR&MASK_i)==BASE_i drives HSEL_S[i]=1; no match -> HSEL_DEF=1.
//    Exactly one of {HSEL_S,HSEL_DEF} high every cycle, independent of HTRANS (slaves qualify with HTRANS).
//  - Data-phase select dsel (NONE | S0..S(N-1) | DEF): on clock edge with HREADY=1,
//    dsel <= address-phase selection if HTRANS[1]=1, else NONE. HREADY=0 -> dsel holds.
//  - Output mux (combinational from dsel): S_i/DEF -> that slave's HRDATA/HREADYOUT/HRESP;
//    NONE -> HRDATA=0, HREADY=1, HRESP=0 (IDLE/BUSY get zero-wait OKAY).
//  - reset (sync): dsel=NONE, so HRDATA=0, HREADY=1, HRESP=0 from the first cycle after reset; HSEL outputs stay pure decode.
//  - reset mid data phase: slave response discarded; next cycle outputs are NONE values.
//  - Latency: HSEL same cycle as HADDR; response muxed in the immediately following data phase(s).
//  - Back-to-back: address phase of transfer N+1 overlaps data phase of N; dsel switches only on HREADY=1.
//  - Two-cycle ERROR from slave (HRESP=1,HREADY=0 then HRESP=1,HREADY=1) passes through unaltered.
// CONFIGURATION
//  - DECODER_WATCHDOG_EN defined: wait counter wd_cnt (WD_WIDTH bits) + FSM {RUN, ERR1, ERR2}.
//    RUN: dsel!=NONE and selected HREADYOUT=0 -> wd_cnt++; else wd_cnt=0.
//    wd_cnt==WD_LIMIT with slave still not ready -> ERR1.
//    ERR1 (1 cycle): HREADY=0, HRESP=1, HRDATA=0, slave ignored -> ERR2.
//    ERR2 (1 cycle): HREADY=1, HRESP=1; dsel captured normally on this edge; wd_cnt=0 -> RUN.
//    reset -> RUN, wd_cnt=0.
//  - Undefined: no counter, no FSM; stalls pass through indefinitely.
// TESTING
//  1 reset asserted 2 cycles, HTRANS=IDLE -> HREADY=1, HRESP=0, HRDATA=0; HSEL follows HADDR.
//  2 HADDR=32'h1000_0040, HTRANS=NONSEQ -> HSEL_S=4'b0010 same cycle; next cycle HRDATA=HRDATA_S[63:32].
//  3 HADDR=32'h8000_0000 NONSEQ -> HSEL_DEF=1, HSEL_S=0; default slave's 2-cycle ERROR seen at HRESP/HREADY exactly.
//  4 Slave 2 holds HREADYOUT=0 for 3 cycles -> HREADY=0 for 3 cycles, dsel held while HADDR changes; then OKAY.
//  5 WATCHDOG_EN, slave 0 stalls forever -> after 16 wait cycles HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then RUN.
//  6 Back-to-back NONSEQ to S3 then S0 with zero waits -> HRDATA switches S3->S0 on consecutive cycles, no bubble.

Source files
------------

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder + slave response mux: HSEL same cycle as HADDR, response muxed in the following data phase(s).
// Stalls follow the selected HREADYOUT; define DECODER_WATCHDOG_EN to cut long stalls short with a two-cycle ERROR.
module ahb_decoder_mux #(
  parameter int                     NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRS = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0] ADDR_MASKS = {4{32'hF000_0000}},
  parameter int                     WD_LIMIT   = 16,
  parameter int                     WD_WIDTH   = 5
) (
  input  logic                      HMASTCLOCK,
  input  logic                      reset,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  output logic [NUM_SLAVES-1:0]     HSEL_S,
  output logic                      HSEL_DEF,
  input  logic [32*NUM_SLAVES-1:0]  HRDATA_S,
  input  logic [NUM_SLAVES-1:0]     HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]     HRESP_S,
  input  logic [31:0]               HRDATA_DEF,
  input  logic                      HREADYOUT_DEF,
  input  logic                      HRESP_DEF,
  output logic [31:0]               HRDATA,
  output logic                      HREADY,
  output logic                      HRESP
);

  localparam int NSEL = NUM_SLAVES + 1;
  localparam int DEF  = NUM_SLAVES;

  logic [NSEL-1:0] w_asel;
  // One-hot data-phase select; bit DEF is the default slave, all-zero means no transfer in flight.
  logic [NSEL-1:0] r_dsel;
  logic [31:0]     w_mux_rdata;
  logic            w_mux_ready;
  logic            w_mux_resp;
  logic            w_unused_htrans;

  assign w_unused_htrans = HTRANS[0];

  always_comb begin : decode
    logic v_hit;
    v_hit  = 1'b0;
    w_asel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!v_hit && ((HADDR & ADDR_MASKS[32*i +: 32]) == BASE_ADDRS[32*i +: 32])) begin
        w_asel[i] = 1'b1;
        v_hit     = 1'b1;
      end
    end
    w_asel[DEF] = !v_hit;
  end

  assign HSEL_S   = w_asel[NUM_SLAVES-1:0];
  assign HSEL_DEF = w_asel[DEF];

  always_comb begin : resp_mux
    w_mux_rdata = '0;
    w_mux_ready = 1'b1;
    w_mux_resp  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_dsel[i]) begin
        w_mux_rdata = HRDATA_S[32*i +: 32];
        w_mux_ready = HREADYOUT_S[i];
        w_mux_resp  = HRESP_S[i];
      end
    end
    if (r_dsel[DEF]) begin
      w_mux_rdata = HRDATA_DEF;
      w_mux_ready = HREADYOUT_DEF;
      w_mux_resp  = HRESP_DEF;
    end
  end

  // Address phase is accepted only when the current data phase completes.
  always_ff @(posedge HMASTCLOCK) begin
    if (reset) begin
      r_dsel <= '0;
    end else if (HREADY) begin
      r_dsel <= HTRANS[1] ? w_asel : '0;
    end
  end

`ifdef DECODER_WATCHDOG_EN
  typedef enum logic [1:0] {WD_RUN, WD_ERR1, WD_ERR2} wd_state_t;

  localparam logic [WD_WIDTH-1:0] WD_LIM = WD_WIDTH'(WD_LIMIT);

  wd_state_t           r_wd_state;
  wd_state_t           w_wd_state_nxt;
  logic [WD_WIDTH-1:0] r_wd_cnt;
  logic [WD_WIDTH-1:0] w_wd_cnt_nxt;
  logic                w_waiting;

  assign w_waiting = (|r_dsel) && !w_mux_ready;

  always_ff @(posedge HMASTCLOCK) begin
    if (reset) begin
      r_wd_state <= WD_RUN;
      r_wd_cnt   <= '0;
    end else begin
      r_wd_state <= w_wd_state_nxt;
      r_wd_cnt   <= w_wd_cnt_nxt;
    end
  end

  // During ERR1/ERR2 the stalled slave is ignored and the master sees a synthesized ERROR.
  always_comb begin
    w_wd_state_nxt = r_wd_state;
    w_wd_cnt_nxt   = '0;
    HRDATA         = w_mux_rdata;
    HREADY         = w_mux_ready;
    HRESP          = w_mux_resp;
    case (r_wd_state)
      WD_RUN: begin
        if (w_waiting) begin
          if (r_wd_cnt == WD_LIM) begin
            w_wd_state_nxt = WD_ERR1;
          end else begin
            w_wd_cnt_nxt = r_wd_cnt + WD_WIDTH'(1);
          end
        end
      end
      WD_ERR1: begin
        HRDATA         = '0;
        HREADY         = 1'b0;
        HRESP          = 1'b1;
        w_wd_state_nxt = WD_ERR2;
      end
      WD_ERR2: begin
        HRDATA         = '0;
        HREADY         = 1'b1;
        HRESP          = 1'b1;
        w_wd_state_nxt = WD_RUN;
      end
      default: begin
        w_wd_state_nxt = WD_RUN;
      end
    endcase
  end
`else
  logic [WD_WIDTH-1:0] w_unused_wd;
  assign w_unused_wd = WD_WIDTH'(WD_LIMIT);

  assign HRDATA = w_mux_rdata;
  assign HREADY = w_mux_ready;
  assign HRESP  = w_mux_resp;
`endif

endmodule
